// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and default sizes for the register-file writeback arbiter.

package regfile_wb_arbiter_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned IDXW_DEF = 5;

    typedef enum logic {
        WB_PORT_A = 1'b0,
        WB_PORT_B = 1'b1
    } wb_port_e;

    typedef struct packed {
        logic [IDXW_DEF-1:0] idx;
        logic [XLEN_DEF-1:0] data;
    } wb_req_t;

endpackage : regfile_wb_arbiter_pkg

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: allocation sets, commit clears, allocation wins ties.
// Register 0 is never busy.

module regfile_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned IDXW = IDXW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_valid,
    input  logic [IDXW-1:0] set_idx,
    input  logic            clr_valid,
    input  logic [IDXW-1:0] clr_idx,
    input  logic [IDXW-1:0] rs1_idx,
    input  logic [IDXW-1:0] rs2_idx,
    output logic            rs1_busy,
    output logic            rs2_busy
);

    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] busy_q;

    // Clear first so a same-cycle allocation to the same register overrides it.
    always_comb begin
        busy_d = busy_q;
        if (clr_valid) begin
            busy_d[clr_idx] = 1'b0;
        end
        if (set_valid && (set_idx != '0)) begin
            busy_d[set_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy = busy_q[rs1_idx];
    assign rs2_busy = busy_q[rs2_idx];

endmodule : regfile_scoreboard

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU (A) and load (B) writebacks onto the single register-file write port.
// Define REGFILE_WB_ROUND_ROBIN_EN for round-robin; otherwise B has fixed priority.

module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned IDXW = IDXW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [IDXW-1:0] a_idx,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [IDXW-1:0] b_idx,
    input  logic [XLEN-1:0] b_data,
    input  logic            alloc_valid,
    input  logic [IDXW-1:0] alloc_idx,
    input  logic [IDXW-1:0] rs1_idx,
    input  logic [IDXW-1:0] rs2_idx,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rf_we,
    output logic [IDXW-1:0] rf_wr_idx,
    output logic [XLEN-1:0] rf_wr_data
);

    logic    grant_a_c;
    logic    grant_b_c;
    logic    xfer_c;
    wb_req_t sel_req_c;
    logic    commit_c;

    logic    rf_we_d;
    logic    rf_we_q;
    wb_req_t wr_d;
    wb_req_t wr_q;

`ifdef REGFILE_WB_ROUND_ROBIN_EN
    wb_port_e rr_last_d;
    wb_port_e rr_last_q;
`endif

    // Grant selection: a lone requester always wins; contention resolved by policy.
    always_comb begin
        grant_a_c = 1'b0;
        grant_b_c = 1'b0;
        if (a_valid && b_valid) begin
`ifdef REGFILE_WB_ROUND_ROBIN_EN
            grant_b_c = (rr_last_q == WB_PORT_A);
`else
            grant_b_c = 1'b1;
`endif
            grant_a_c = !grant_b_c;
        end else begin
            grant_a_c = a_valid;
            grant_b_c = b_valid;
        end
    end

    assign a_ready = grant_a_c & rst_n;
    assign b_ready = grant_b_c & rst_n;
    assign xfer_c  = grant_a_c | grant_b_c;

    always_comb begin
        sel_req_c.idx  = IDXW_DEF'(a_idx);
        sel_req_c.data = XLEN_DEF'(a_data);
        if (grant_b_c) begin
            sel_req_c.idx  = IDXW_DEF'(b_idx);
            sel_req_c.data = XLEN_DEF'(b_data);
        end
    end

    // Writes to register 0 are consumed but never reach the register file.
    assign commit_c = xfer_c && (sel_req_c.idx != '0);

    always_comb begin
        rf_we_d = commit_c;
        wr_d    = wr_q;
        if (xfer_c) begin
            wr_d = sel_req_c;
        end
    end

`ifdef REGFILE_WB_ROUND_ROBIN_EN
    always_comb begin
        rr_last_d = rr_last_q;
        if (xfer_c) begin
            rr_last_d = grant_b_c ? WB_PORT_B : WB_PORT_A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= WB_PORT_B;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q <= 1'b0;
            wr_q    <= '0;
        end else begin
            rf_we_q <= rf_we_d;
            wr_q    <= wr_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_wr_idx  = IDXW'(wr_q.idx);
    assign rf_wr_data = XLEN'(wr_q.data);

    regfile_scoreboard #(
        .NREG (NREG),
        .IDXW (IDXW)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_valid (alloc_valid),
        .set_idx   (alloc_idx),
        .clr_valid (commit_c),
        .clr_idx   (IDXW'(sel_req_c.idx)),
        .rs1_idx   (rs1_idx),
        .rs2_idx   (rs2_idx),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy)
    );

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table, contention/reset
// sequences, and randomized traffic against a behavioural model.

module tb_regfile_wb_arbiter;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned IDXW = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            a_valid, b_valid, alloc_valid;
    logic            a_ready, b_ready;
    logic [IDXW-1:0] a_idx, b_idx, alloc_idx, rs1_idx, rs2_idx;
    logic [XLEN-1:0] a_data, b_data;
    logic            rs1_busy, rs2_busy;
    logic            rf_we;
    logic [IDXW-1:0] rf_wr_idx;
    logic [XLEN-1:0] rf_wr_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .IDXW(IDXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_data(b_data),
        .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data)
    );

    typedef struct {
        logic        av;  logic [4:0] ai;  logic [31:0] ad;
        logic        bv;  logic [4:0] bi;  logic [31:0] bd;
        logic        alv; logic [4:0] ali;
        logic [4:0]  r1;  logic [4:0] r2;
        logic        ear; logic ebr; logic ewe;
        logic [4:0]  eidx; logic [31:0] edata;
        logic        eb1; logic eb2;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(
        input logic av, input logic [4:0] ai, input logic [31:0] ad,
        input logic bv, input logic [4:0] bi, input logic [31:0] bd,
        input logic alv, input logic [4:0] ali,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic ear, input logic ebr, input logic ewe,
        input logic [4:0] eidx, input logic [31:0] edata,
        input logic eb1, input logic eb2);
        vec_t v;
        v.av = av; v.ai = ai; v.ad = ad; v.bv = bv; v.bi = bi; v.bd = bd;
        v.alv = alv; v.ali = ali; v.r1 = r1; v.r2 = r2;
        v.ear = ear; v.ebr = ebr; v.ewe = ewe; v.eidx = eidx; v.edata = edata;
        v.eb1 = eb1; v.eb2 = eb2;
        return v;
    endfunction

    // Called just after a posedge: drive, check readies mid-cycle, check results after the edge.
    task automatic apply(input vec_t v, input int n);
        a_valid = v.av; a_idx = v.ai; a_data = v.ad;
        b_valid = v.bv; b_idx = v.bi; b_data = v.bd;
        alloc_valid = v.alv; alloc_idx = v.ali;
        rs1_idx = v.r1; rs2_idx = v.r2;
        @(negedge clk);
        chk($sformatf("vec%0d a_ready", n), 32'(a_ready), 32'(v.ear));
        chk($sformatf("vec%0d b_ready", n), 32'(b_ready), 32'(v.ebr));
        @(posedge clk); #1;
        chk($sformatf("vec%0d rf_we", n), 32'(rf_we), 32'(v.ewe));
        if (v.ewe) begin
            chk($sformatf("vec%0d rf_wr_idx", n), 32'(rf_wr_idx), 32'(v.eidx));
            chk($sformatf("vec%0d rf_wr_data", n), rf_wr_data, v.edata);
        end
        chk($sformatf("vec%0d rs1_busy", n), 32'(rs1_busy), 32'(v.eb1));
        chk($sformatf("vec%0d rs2_busy", n), 32'(rs2_busy), 32'(v.eb2));
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_idx = '0; a_data = '0;
        b_valid = 1'b0; b_idx = '0; b_data = '0;
        alloc_valid = 1'b0; alloc_idx = '0;
        rs1_idx = '0; rs2_idx = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Behavioural model state for the random phase.
    bit   mbusy[NREG];
    int   mlast;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        bit a_pend, b_pend, exp_a, exp_b, ewe;
        logic [4:0]  widx;
        logic [31:0] wdata;

        idle_inputs();
        rst_n = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        #12;
        chk("reset a_ready", 32'(a_ready), 32'd0);
        chk("reset b_ready", 32'(b_ready), 32'd0);
        chk("reset rf_we", 32'(rf_we), 32'd0);
        chk("reset rf_wr_idx", 32'(rf_wr_idx), 32'd0);
        chk("reset rf_wr_data", rf_wr_data, 32'd0);
        chk("reset rs1_busy", 32'(rs1_busy), 32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        tbl[0] = mkv(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0,
                     1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        tbl[1] = mkv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0,
                     1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        tbl[2] = mkv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0,
                     1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        tbl[3] = mkv(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd0,
                     1'b0, 1'b1, 1'b1, 5'd7, 32'h77, 1'b0, 1'b0);
        tbl[4] = mkv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0,
                     1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        tbl[5] = mkv(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0,
                     1'b1, 1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 1'b0);
        tbl[6] = mkv(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd9, 5'd0,
                     1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        tbl[7] = mkv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd9,
                     1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        tbl[8] = mkv(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hAB, 1'b1, 5'd3, 5'd3, 5'd9,
                     1'b0, 1'b1, 1'b1, 5'd9, 32'hAB, 1'b1, 1'b0);
        tbl[9] = mkv(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd3, 5'd7,
                     1'b0, 1'b1, 1'b1, 5'd3, 32'h33, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i], i);
        end

        // Continuous contention from a fresh reset.
        do_reset();
        a_valid = 1'b1; a_idx = 5'd3; a_data = 32'h11;
        b_valid = 1'b1; b_idx = 5'd4; b_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
`ifdef REGFILE_WB_ROUND_ROBIN_EN
            exp_b = (i % 2) == 1;
`else
            exp_b = 1'b1;
`endif
            @(negedge clk);
            chk($sformatf("contend%0d a_ready", i), 32'(a_ready), 32'(!exp_b));
            chk($sformatf("contend%0d b_ready", i), 32'(b_ready), 32'(exp_b));
            @(posedge clk); #1;
            chk($sformatf("contend%0d rf_we", i), 32'(rf_we), 32'd1);
            chk($sformatf("contend%0d rf_wr_idx", i), 32'(rf_wr_idx), exp_b ? 32'd4 : 32'd3);
            chk($sformatf("contend%0d rf_wr_data", i), rf_wr_data, exp_b ? 32'h22 : 32'h11);
        end
        idle_inputs();
        @(posedge clk); #1;
        chk("contend_end rf_we", 32'(rf_we), 32'd0);

        // Asynchronous reset while a write is presented and a register is busy.
        alloc_valid = 1'b1; alloc_idx = 5'd12; rs1_idx = 5'd12;
        a_valid = 1'b1; a_idx = 5'd13; a_data = 32'h5A5A5A5A;
        @(posedge clk); #1;
        idle_inputs();
        rs1_idx = 5'd12;
        chk("prerst rf_we", 32'(rf_we), 32'd1);
        chk("prerst rs1_busy", 32'(rs1_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        a_valid = 1'b1;
        #1;
        chk("midrst rf_we", 32'(rf_we), 32'd0);
        chk("midrst rf_wr_idx", 32'(rf_wr_idx), 32'd0);
        chk("midrst rf_wr_data", rf_wr_data, 32'd0);
        chk("midrst rs1_busy", 32'(rs1_busy), 32'd0);
        chk("midrst a_ready", 32'(a_ready), 32'd0);
        a_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic against the behavioural model.
        for (int r = 0; r < NREG; r++) mbusy[r] = 1'b0;
        mlast = 1;
        a_pend = 1'b0; b_pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!a_pend && ($urandom_range(0, 2) != 0)) begin
                a_pend = 1'b1;
                a_idx  = 5'($urandom_range(0, 31));
                a_data = $urandom;
            end
            if (!b_pend && ($urandom_range(0, 2) == 0)) begin
                b_pend = 1'b1;
                b_idx  = 5'($urandom_range(0, 31));
                b_data = $urandom;
            end
            a_valid = a_pend;
            b_valid = b_pend;
            alloc_valid = ($urandom_range(0, 2) == 0);
            alloc_idx = 5'($urandom_range(0, 31));
            rs1_idx = 5'($urandom_range(0, 31));
            rs2_idx = 5'($urandom_range(0, 31));

            if (a_pend && b_pend) begin
`ifdef REGFILE_WB_ROUND_ROBIN_EN
                exp_b = (mlast == 0);
`else
                exp_b = 1'b1;
`endif
                exp_a = !exp_b;
            end else begin
                exp_a = a_pend;
                exp_b = b_pend;
            end

            @(negedge clk);
            chk($sformatf("rand%0d a_ready", c), 32'(a_ready), 32'(exp_a));
            chk($sformatf("rand%0d b_ready", c), 32'(b_ready), 32'(exp_b));
            @(posedge clk); #1;

            ewe = 1'b0; widx = '0; wdata = '0;
            if (exp_a || exp_b) begin
                widx  = exp_b ? b_idx : a_idx;
                wdata = exp_b ? b_data : a_data;
                ewe   = (widx != 0);
                if (ewe) mbusy[widx] = 1'b0;
                mlast = exp_b ? 1 : 0;
            end
            if (alloc_valid && alloc_idx != 0) mbusy[alloc_idx] = 1'b1;
            if (exp_a) a_pend = 1'b0;
            if (exp_b) b_pend = 1'b0;

            chk($sformatf("rand%0d rf_we", c), 32'(rf_we), 32'(ewe));
            if (ewe) begin
                chk($sformatf("rand%0d rf_wr_idx", c), 32'(rf_wr_idx), 32'(widx));
                chk($sformatf("rand%0d rf_wr_data", c), rf_wr_data, wdata);
            end
            chk($sformatf("rand%0d rs1_busy", c), 32'(rs1_busy), 32'(mbusy[rs1_idx]));
            chk($sformatf("rand%0d rs2_busy", c), 32'(rs2_busy), 32'(mbusy[rs2_idx]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
